// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 8N1 UART receiver feeding the MemoryUnit UART read port.
// Two-flop input synchroniser, mid-bit sampling, read-to-clear status flags.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1 and adds rx_parity_error.
module uart_rx_unit #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       uart_in,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_interrupt,
  output logic       rx_frame_error,
`ifdef UART_RX_PARITY_EN
  output logic       rx_parity_error,
`endif
  output logic       rx_overrun
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    COMMIT,
    WAIT_IDLE
  } state_t;

  state_t           state, state_n;
  logic             sync1, rxs;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic [7:0]       rx_data_n;
  logic             rx_valid_n;
  logic             rx_interrupt_n;
  logic             rx_frame_error_n;
  logic             rx_overrun_n;
`ifdef UART_RX_PARITY_EN
  logic             rx_parity_error_n;
`endif

  // Input synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_in;
      rxs   <= sync1;
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      rx_data        <= 8'h00;
      rx_valid       <= 1'b0;
      rx_interrupt   <= 1'b0;
      rx_frame_error <= 1'b0;
      rx_overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_error <= 1'b0;
`endif
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      bit_idx        <= bit_idx_n;
      shreg          <= shreg_n;
      rx_data        <= rx_data_n;
      rx_valid       <= rx_valid_n;
      rx_interrupt   <= rx_interrupt_n;
      rx_frame_error <= rx_frame_error_n;
      rx_overrun     <= rx_overrun_n;
`ifdef UART_RX_PARITY_EN
      rx_parity_error <= rx_parity_error_n;
`endif
    end
  end

  // Next-state and output logic; rd clears flags unless a set happens this cycle.
  always_comb begin
    state_n          = state;
    cnt_n            = cnt;
    bit_idx_n        = bit_idx;
    shreg_n          = shreg;
    rx_data_n        = rx_data;
    rx_valid_n       = rx_valid & ~rd;
    rx_interrupt_n   = 1'b0;
    rx_frame_error_n = rx_frame_error & ~rd;
    rx_overrun_n     = rx_overrun & ~rd;
`ifdef UART_RX_PARITY_EN
    rx_parity_error_n = rx_parity_error & ~rd;
`endif

    case (state)
      IDLE: begin
        if (!rxs) begin
          cnt_n   = '0;
          state_n = START;
        end
      end

      START: begin
        if (cnt == CNT_MID) begin
          if (rxs) begin
            state_n = IDLE;
          end else begin
            cnt_n     = '0;
            bit_idx_n = '0;
            state_n   = DATA;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rxs, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      // Even parity: data bits plus parity bit must XOR to zero.
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if ((^shreg) ^ rxs) begin
            rx_parity_error_n = 1'b1;
          end
          state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`endif

      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rxs) begin
            state_n = COMMIT;
          end else begin
            rx_frame_error_n = 1'b1;
            state_n          = WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      // Commit wins over a simultaneous rd; overrun only if the old byte stays unread.
      COMMIT: begin
        rx_data_n      = shreg;
        rx_valid_n     = 1'b1;
        rx_interrupt_n = 1'b1;
        if (rx_valid && !rd) begin
          rx_overrun_n = 1'b1;
        end
        state_n = IDLE;
      end

      // Hold off a break condition until the line returns high.
      WAIT_IDLE: begin
        if (rxs) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Testbench for uart_rx_unit: directed and random frames against a byte-level model.
module tb_uart_rx_unit;

  localparam int CPB = 50000000 / 115200;

  logic       clk = 1'b0;
  logic       nreset;
  logic       uart_in;
  logic       rd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_interrupt;
  logic       rx_frame_error;
  logic       rx_overrun;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_error;
`endif

  uart_rx_unit dut (
    .clk            (clk),
    .nreset         (nreset),
    .uart_in        (uart_in),
    .rd             (rd),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_interrupt   (rx_interrupt),
    .rx_frame_error (rx_frame_error),
`ifdef UART_RX_PARITY_EN
    .rx_parity_error(rx_parity_error),
`endif
    .rx_overrun     (rx_overrun)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Cycle counter and interrupt monitor.
  int cyc = 0;
  int irq_cnt = 0;
  int irq_wide = 0;
  int last_irq_cyc = 0;
  logic prev_irq = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_irq <= rx_interrupt;
    if (rx_interrupt) begin
      irq_cnt      <= irq_cnt + 1;
      last_irq_cyc <= cyc;
      if (prev_irq) irq_wide <= irq_wide + 1;
    end
  end

  // Byte-level reference state.
  logic [7:0] exp_data;
  logic       exp_valid, exp_ferr, exp_ovr;
  int         exp_irq;
  int         start_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"},  32'(rx_data),        32'(exp_data));
    chk({tag, ".valid"}, 32'(rx_valid),       32'(exp_valid));
    chk({tag, ".ferr"},  32'(rx_frame_error), 32'(exp_ferr));
    chk({tag, ".ovr"},   32'(rx_overrun),     32'(exp_ovr));
    chk({tag, ".irqs"},  32'(irq_cnt),        32'(exp_irq));
    chk({tag, ".wide"},  32'(irq_wide),       32'd0);
`ifdef UART_RX_PARITY_EN
    chk({tag, ".perr"},  32'(rx_parity_error), 32'd0);
`endif
  endtask

  task automatic idle_bits(input int n);
    for (int k = 0; k < n * CPB; k++) begin
      @(negedge clk);
      uart_in = 1'b1;
    end
  endtask

  // Drive one frame; rst_bit >= 0 pulses nreset low mid-way through that wire bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rst_bit);
    logic bits[$];
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(stop_bit);
    for (int i = 0; i < bits.size(); i++) begin
      for (int k = 0; k < CPB; k++) begin
        @(negedge clk);
        if (k == 0) uart_in = bits[i];
        if (i == 0 && k == 0) start_cyc = cyc;
        if (i == rst_bit && k == 200) nreset = 1'b0;
        if (i == rst_bit && k == 203) nreset = 1'b1;
      end
    end
    // Model: reset drops everything, a good stop commits, a bad stop flags.
    if (rst_bit >= 0) begin
      exp_data  = 8'h00;
      exp_valid = 1'b0;
      exp_ferr  = 1'b0;
      exp_ovr   = 1'b0;
    end else if (stop_bit) begin
      if (exp_valid) exp_ovr = 1'b1;
      exp_data  = b;
      exp_valid = 1'b1;
      exp_irq++;
    end else begin
      exp_ferr = 1'b1;
    end
  endtask

  task automatic do_rd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    exp_valid = 1'b0;
    exp_ferr  = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    logic       rstop;
    int         lat;

    exp_data  = 8'h00;
    exp_valid = 1'b0;
    exp_ferr  = 1'b0;
    exp_ovr   = 1'b0;
    exp_irq   = 0;
    start_cyc = 0;
    nreset    = 1'b0;
    uart_in   = 1'b1;
    rd        = 1'b0;

    // Reset with the line toggling.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      uart_in = k[0];
    end
    @(negedge clk);
    uart_in = 1'b1;
    check_all("reset");
    nreset = 1'b1;
    idle_bits(1);
    check_all("post_reset");

    // Single byte and its latency.
    send_frame(8'hA5, 1'b1, -1);
    lat = last_irq_cyc - start_cyc;
    chk("a5.latency_ok", 32'(lat >= 4100 && lat <= 4160), 32'd1);
    idle_bits(1);
    check_all("a5");
    do_rd();
    check_all("a5.rd");

    // Short glitch is ignored.
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      uart_in = 1'b0;
    end
    idle_bits(2);
    check_all("glitch");

    // Framing error, then recovery with a good byte.
    send_frame(8'h3C, 1'b0, -1);
    idle_bits(2);
    check_all("ferr");
    send_frame(8'h55, 1'b1, -1);
    idle_bits(1);
    check_all("after_ferr");
    do_rd();
    check_all("ferr.rd");

    // Overrun.
    send_frame(8'h11, 1'b1, -1);
    idle_bits(1);
    send_frame(8'h22, 1'b1, -1);
    idle_bits(1);
    check_all("overrun");
    do_rd();
    check_all("overrun.rd");

    // Reset during data bit 4 (wire bit 5) abandons the frame.
    send_frame(8'hFF, 1'b1, 5);
    idle_bits(1);
    check_all("midreset");
    send_frame(8'h01, 1'b1, -1);
    idle_bits(1);
    check_all("after_midreset");

    // Random bytes, occasional bad stop bit, random reads.
    for (int n = 0; n < 5; n++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      send_frame(rb, rstop, -1);
      idle_bits(1);
      check_all($sformatf("rand%0d", n));
      if ($urandom_range(0, 1) == 1) begin
        do_rd();
        check_all($sformatf("rand%0d.rd", n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
